// File: rtl/adc_pkg.sv
// Shared types and helpers for the serial-ADC capture engine.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  // Minimum clk cycles from one frame start to the next.
  function automatic int frame_cycles(input int clk_div, input int frame_bits,
                                      input int cs_high_cyc);
    return 2 * clk_div * frame_bits + cs_high_cyc;
  endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// Pin/datapath bundle of the ADC capture engine: control, ADC pins and results.
interface adc_spi_capture_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 12
);
  logic                     cont;
  logic                     start;
  logic [N_CH-1:0]          sdo;
  logic                     cs_n;
  logic                     sclk;
  logic [N_CH*DATA_W-1:0]   data;
  logic                     valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    input  cont, start, sdo,
    output cs_n, sclk, data, valid, busy, overrun
  );

  modport slave (
    output cont, start, sdo,
    input  cs_n, sclk, data, valid, busy, overrun
  );
endinterface

// File: rtl/adc_shift_ch.sv
// One ADC channel: shifts SDO on each rising SCLK, keeping only the result window.
module adc_shift_ch #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 2,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sample_en,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              sdo,
  output logic [DATA_W-1:0] result
);

  logic in_window;

  // Exactly DATA_W bits land in the window, so stale bits shift out without a clear.
  assign in_window = (int'(bit_idx) >= LEAD_BITS) &&
                     (int'(bit_idx) <  LEAD_BITS + DATA_W);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      result <= '0;
    end else if (sample_en && in_window) begin
      result <= {result[DATA_W-2:0], sdo};
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial-ADC capture engine: shared CS/SCLK, N_CH parallel SDO lines, framed results.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_BITS   = 2,
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 4,
  parameter int N_CH        = 2
) (
  input logic              clk,
  input logic              nrst,
  adc_spi_capture_if.master bus
);

  localparam int BC_W  = $clog2(FRAME_BITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int Q_W   = $clog2(CS_HIGH_CYC + 1);

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [BC_W-1:0]         bit_cnt;
  logic [Q_W-1:0]          q_cnt;
  logic                    pend;
  logic                    cs_n_q, sclk_q, valid_q, busy_q, overrun_q;
  logic [N_CH*DATA_W-1:0]  data_q;
  logic [N_CH*DATA_W-1:0]  res_flat;
  logic                    start_eff, div_tc, sample_en;

  assign start_eff = bus.start & ~bus.cont;
  assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sample_en = (state == SHIFT) && div_tc && !sclk_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    adc_shift_ch #(
      .DATA_W    (DATA_W),
      .LEAD_BITS (LEAD_BITS),
      .IDX_W     (BC_W)
    ) u_ch (
      .clk       (clk),
      .nrst      (nrst),
      .sample_en (sample_en),
      .bit_idx   (bit_cnt),
      .sdo       (bus.sdo[i]),
      .result    (res_flat[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      q_cnt     <= '0;
      pend      <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      // One start may wait for the next frame; a second one while it waits is lost.
      if (busy_q && start_eff) begin
        if (pend) overrun_q <= 1'b1;
        else      pend      <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (bus.cont || bus.start) begin
            state   <= SHIFT;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (!sclk_q) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BC_W'(FRAME_BITS - 1)) begin
                state  <= DONE;
                cs_n_q <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          data_q  <= res_flat;
          valid_q <= 1'b1;
          q_cnt   <= Q_W'(1);
          state   <= QUIET;
        end
        QUIET: begin
          if (q_cnt >= Q_W'(CS_HIGH_CYC - 1)) begin
            q_cnt <= '0;
            // A start arriving in this very cycle is serviced directly.
            if (bus.cont || pend || start_eff) begin
              state   <= SHIFT;
              cs_n_q  <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
              pend    <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            q_cnt <= q_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cs_n    = cs_n_q;
  assign bus.sclk    = sclk_q;
  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule
